// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM state type
// and the funct3 legality rule used by the alignment logic.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_RESP
    } memstate_t;

    // Stores only have signed-style widths; loads also have the unsigned ones.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: load extraction/extension, sub-word store merge and
// misaligned/illegal access detection.
module mem_align
    import mem_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word,
    output logic        bad
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        misaligned;

    always_comb begin
        lane_b = word[7:0];
        case (addr_lo)
            2'd0: lane_b = word[7:0];
            2'd1: lane_b = word[15:8];
            2'd2: lane_b = word[23:16];
            2'd3: lane_b = word[31:24];
            default: lane_b = word[7:0];
        endcase
        lane_h = addr_lo[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        load_val = word;
        case (funct3)
            F3_B:    load_val = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_val = {24'h000000, lane_b};
            F3_H:    load_val = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_val = {16'h0000, lane_h};
            default: load_val = word;
        endcase
    end

    // Read-modify-write merge: only the addressed lane takes the new data.
    always_comb begin
        store_word = word;
        case (funct3)
            F3_B: begin
                case (addr_lo)
                    2'd0: store_word[7:0]   = wdata[7:0];
                    2'd1: store_word[15:8]  = wdata[7:0];
                    2'd2: store_word[23:16] = wdata[7:0];
                    2'd3: store_word[31:24] = wdata[7:0];
                    default: store_word = word;
                endcase
            end
            F3_H: begin
                if (addr_lo[1]) store_word[31:16] = wdata;
                else            store_word[15:0]  = wdata;
            end
            default: store_word = word;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (funct3)
            F3_H, F3_HU: misaligned = addr_lo[0];
            F3_W:        misaligned = (addr_lo != 2'b00);
            default:     misaligned = 1'b0;
        endcase
        bad = misaligned || !f3_legal(is_store, funct3);
    end

endmodule

// File: rtl/mem_ctrl.sv
// Load/store unit FSM between the multicycle datapath and a word-wide BRAM.
// Sub-word stores are done as read-modify-write since the BRAM has no byte enables.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int MEM_AW = 12,
    parameter int RD_LAT = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              busy,
    output logic              err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

    memstate_t   state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;
    logic [15:0] wd_q;
    logic [1:0]  wait_cnt;

    logic        al_store;
    logic [2:0]  al_f3;
    logic [1:0]  al_lo;
    logic [31:0] load_val;
    logic [31:0] store_word;
    logic        bad;
    logic        unused_addr_hi;

    // Upper address bits alias the memory and are deliberately dropped.
    assign unused_addr_hi = ^addr[31:MEM_AW+2];

    // In IDLE the checker looks at the live request; afterwards at the captured one.
    assign al_store = (state == ST_IDLE) ? we     : we_q;
    assign al_f3    = (state == ST_IDLE) ? funct3 : f3_q;
    assign al_lo    = (state == ST_IDLE) ? addr[1:0] : lo_q;

    mem_align u_align (
        .is_store   (al_store),
        .funct3     (al_f3),
        .addr_lo    (al_lo),
        .word       (mem_rdata),
        .wdata      (wd_q),
        .load_val   (load_val),
        .store_word (store_word),
        .bad        (bad)
    );

    // Single FSM; every output is registered and set on the transition into the
    // state it belongs to, so strobes drop together with an async reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            lo_q      <= 2'b00;
            wd_q      <= 16'h0000;
            wait_cnt  <= 2'b00;
            rdata     <= 32'h0000_0000;
            done      <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= 32'h0000_0000;
        end else begin
            done   <= 1'b0;
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        we_q     <= we;
                        f3_q     <= funct3;
                        lo_q     <= addr[1:0];
                        wd_q     <= wdata[15:0];
                        mem_addr <= addr[MEM_AW+1:2];
                        busy     <= 1'b1;
                        if (bad) begin
                            state <= ST_RESP;
                            err   <= 1'b1;
                            done  <= 1'b1;
                        end else if (we && funct3 == F3_W) begin
                            state     <= ST_WRITE;
                            err       <= 1'b0;
                            mem_we    <= 1'b1;
                            mem_wdata <= wdata;
                        end else begin
                            state  <= ST_READ;
                            err    <= 1'b0;
                            mem_re <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    state    <= ST_WAIT;
                    wait_cnt <= WAIT_INIT;
                end
                ST_WAIT: begin
                    if (wait_cnt != 2'b00) begin
                        wait_cnt <= wait_cnt - 2'b01;
                    end else if (we_q) begin
                        state     <= ST_WRITE;
                        mem_we    <= 1'b1;
                        mem_wdata <= store_word;
                    end else begin
                        state <= ST_RESP;
                        done  <= 1'b1;
                        rdata <= load_val;
                    end
                end
                ST_WRITE: begin
                    state <= ST_RESP;
                    done  <= 1'b1;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    err   <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Load/store unit between the multicycle datapath (address mux, write-data register, result mux) and a single-port, word-wide synchronous BRAM with no byte enables.
- Executes one RV32I memory access per request: LB/LH/LW/LBU/LHU and SB/SH/SW.
- Extracts and sign/zero-extends loaded sub-words.
- Performs read-modify-write for sub-word stores.
- Flags misaligned or illegal accesses.
- Signals completion so the control FSM can hold its memory states until the access finishes.

Parameters:
- MEM_AW, 12, word-address width of the BRAM (4096 words)
- RD_LAT, 1, BRAM read latency in cycles (1..3)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req  in  1  access request; sampled only in IDLE
- we  in  1  1 = store, 0 = load
- funct3  in  3  RV32I width/sign code
- addr  in  32  byte address
- wdata  in  32  store data (low bits used for SB/SH)
- rdata  out  32  extended load result; registered, held until the next load completes
- done  out  1  one-cycle completion pulse
- busy  out  1  high in every state except IDLE
- err  out  1  valid with done; misaligned or illegal funct3
- mem_addr  out  MEM_AW  word address, addr[MEM_AW+1:2]
- mem_re  out  1  BRAM read strobe
- mem_we  out  1  BRAM write strobe
- mem_wdata  out  32  BRAM write data
- mem_rdata  in  32  BRAM read data, valid RD_LAT cycles after mem_re

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - rdata=0, done=0, err=0, busy=0, mem_re=0, mem_we=0, mem_wdata=0, mem_addr=0.
  - All captured request registers are cleared.
- Acceptance: in IDLE with req=1, the block registers we, funct3, addr and wdata. Later input changes are ignored. req outside IDLE is ignored.
- States: IDLE, READ, WAIT, WRITE, RESP.
  - IDLE -> RESP: access is misaligned or illegal.
  - IDLE -> READ: load, or store with funct3 SB/SH.
  - IDLE -> WRITE: SW.
  - READ: mem_re=1 for exactly one cycle -> WAIT.
  - WAIT: lasts RD_LAT cycles. mem_rdata is captured at the end of the last WAIT cycle. Load -> RESP; sub-word store -> WRITE.
  - WRITE: mem_we=1 for exactly one cycle -> RESP.
  - RESP: done=1 for one cycle -> IDLE.
- Latency (request accepted in cycle 0; done cycle):
  - load: 2+RD_LAT
  - SW: 2
  - SB/SH: 3+RD_LAT
  - error: 1
- A request held high through RESP is re-accepted in the following IDLE cycle. There is a minimum one idle cycle between accesses.
- Loads:
  - byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - rdata updates in the RESP cycle.
- Sub-word stores:
  - SB replaces byte lane addr[1:0] of the read word with wdata[7:0].
  - SH replaces half lane addr[1] with wdata[15:0].
  - All other bytes are preserved.
- Legal funct3 values:
  - loads: 000, 001, 010, 100, 101
  - stores: 000, 001, 010
- Errors:
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
  - Any error gives err=1 with done. The BRAM is never accessed, and rdata is unchanged.
- Address wrap: bits above MEM_AW+1 are ignored, so addresses alias modulo memory size.
- Strobe timing: mem_re and mem_we are decoded from registered state only, so both are 0 in the cycle rst asserts.
- Reset mid-operation: an in-flight read-modify-write is abandoned with no write. There is no done pulse for the aborted access.
- mem_we and mem_re are never both 1 in the same cycle.

Decomposition:
- Package mem_pkg:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State enum typedef memstate_t.
- Sub-module mem_align (combinational):
  - inputs: funct3, addr[1:0], a 32-bit word, wdata
  - outputs: extended load value, merged store word, misaligned/illegal flag
  - mem_ctrl holds only the FSM, the WAIT counter and the registers.

Test Plan:
- LW, addr 0x10, mem[4]=0xDEADBEEF, RD_LAT=1 -> done in cycle 3, rdata=0xDEADBEEF, err=0, one mem_re pulse, mem_addr=4.
- LB, addr 0x13, word 0x80FF1234 -> rdata=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at addr 0x12 -> 0x000080FF.
- SH, addr 0x22, wdata 0x0000ABCD, mem[8]=0x11223344 -> one mem_we pulse with mem_wdata=0xABCD3344, done in cycle 4. SB at addr 0x21, wdata 0x55 -> 0x11225544.
- SW, addr 0x06 -> done in cycle 1, err=1, mem_re and mem_we never asserted. LH at 0x03 and funct3=011 (load) likewise give err=1.
- rst driven low during WAIT of an SB -> busy=0 immediately, mem_we never asserted, memory word unchanged, no done pulse.
- req held high for two LWs with RD_LAT=3 -> done pulses in cycles 5 and 11. Changing addr while busy has no effect on the first result.
